mems_spi_rx: RTL and testbench

MEMS_SPI_RX -- requirements
Module: mems_spi_rx

---
 rtl/mems_spi_pkg.sv | 13 +
 rtl/sync_2ff.sv | 23 ++
 rtl/mems_spi_rx.sv | 146 ++++++++++++++
 tb/tb_mems_spi_rx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mems_spi_pkg.sv
// Shared mems SPI definitions: default frame length, FSM encodings and the bit counter width.
package mems_spi_pkg;

  localparam int unsigned FRAME_BITS_DEF = 24;
  localparam int unsigned CNT_W          = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mems_spi_rx.sv
// SPI mode-1 frame receiver for the mems sensor link, oversampled on clk.
// Optional sck-idle timeout inside a frame: define MEMS_SPI_RX_TIMEOUT_EN.
module mems_spi_rx
  import mems_spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS     = FRAME_BITS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  CS,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  new_data,
  output logic                  frame_err,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  if (FRAME_BITS < 2 || FRAME_BITS + 1 >= (32'(1) << CNT_W) || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mems_spi_rx: FRAME_BITS+1 must fit the bit counter and TIMEOUT_CYCLES must be nonzero");
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_d, cs_d;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst_n(rst_n), .d(sck),  .q(sck_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(CS),   .q(cs_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

  logic sck_fall, sck_edge, cs_fall, cs_rise;
  assign sck_fall = sck_d & ~sck_s;
  assign sck_edge = sck_d ^ sck_s;
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;

  spi_state_e            state, state_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [FRAME_BITS-1:0] data_nxt;
  logic                  new_data_nxt, frame_err_nxt;
  logic                  cs_fall_pend;
  logic                  timed_out, timed_out_nxt, timeout_hit;

`ifdef MEMS_SPI_RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
  assign timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, datapath and output pulse decode
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    cnt_nxt       = cnt;
    data_nxt      = data_out;
    new_data_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    timed_out_nxt = timed_out;
`ifdef MEMS_SPI_RX_TIMEOUT_EN
    idle_cnt_nxt  = idle_cnt;
`endif
    case (state)
      ST_IDLE: begin
        // A CS fall seen while in DONE is replayed here if CS is still low
        if (cs_fall || (cs_fall_pend && !cs_s)) begin
          state_nxt     = ST_RECV;
          shreg_nxt     = '0;
          cnt_nxt       = '0;
          timed_out_nxt = 1'b0;
`ifdef MEMS_SPI_RX_TIMEOUT_EN
          idle_cnt_nxt  = '0;
`endif
        end
      end
      ST_RECV: begin
`ifdef MEMS_SPI_RX_TIMEOUT_EN
        idle_cnt_nxt = sck_edge ? '0 : idle_cnt + IDLE_W'(1);
`endif
        if (cs_rise) begin
          state_nxt = ST_DONE;
        end else if (timeout_hit) begin
          state_nxt     = ST_DONE;
          timed_out_nxt = 1'b1;
        end else if (sck_fall && cnt != CNT_SAT) begin
          shreg_nxt = {shreg[FRAME_BITS-2:0], mosi_s};
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if (cnt == CNT_FULL && !timed_out) begin
          data_nxt     = shreg;
          new_data_nxt = 1'b1;
        end else begin
          frame_err_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      cnt          <= '0;
      data_out     <= '0;
      new_data     <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
      sck_d        <= 1'b0;
      cs_d         <= 1'b1;
      cs_fall_pend <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      cnt          <= cnt_nxt;
      data_out     <= data_nxt;
      new_data     <= new_data_nxt;
      frame_err    <= frame_err_nxt;
      busy         <= (state_nxt != ST_IDLE);
      sck_d        <= sck_s;
      cs_d         <= cs_s;
      cs_fall_pend <= (state == ST_DONE) && cs_fall;
      timed_out    <= timed_out_nxt;
    end
  end

`ifdef MEMS_SPI_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt <= '0;
    else        idle_cnt <= idle_cnt_nxt;
  end
`else
  logic unused_edge;
  assign unused_edge = sck_edge;
`endif

endmodule

// File: tb/tb_mems_spi_rx.sv
// Directed bench for mems_spi_rx; timeout sequence runs when MEMS_SPI_RX_TIMEOUT_EN is defined.
module tb_mems_spi_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck, mosi, CS;
  logic [23:0] data_out;
  logic        new_data, frame_err, busy;

  int tests = 0;
  int fails = 0;
  int nd_cnt, fe_cnt;
  logic [23:0] last_nd;

  mems_spi_rx dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .CS(CS),
    .data_out(data_out), .new_data(new_data), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts cycles each strobe is high
  always @(negedge clk) begin
    if (rst_n) begin
      if (new_data) begin
        nd_cnt  = nd_cnt + 1;
        last_nd = data_out;
      end
      if (frame_err) fe_cnt = fe_cnt + 1;
    end
  end

  typedef struct {
    int          nbits;
    logic [31:0] value;
    int          exp_nd;
    int          exp_fe;
    logic [23:0] exp_data;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sck = clk/16: master drives mosi after the rise, receiver samples at the fall
  task automatic shift_bits(input logic [31:0] value, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sck = 1'b1; mosi = value[i]; tick(8);
      sck = 1'b0; tick(8);
    end
  endtask

  task automatic send_frame(input logic [31:0] value, input int nbits);
    CS = 1'b0; tick(8);
    shift_bits(value, nbits);
    tick(8);
    CS = 1'b1;
  endtask

  initial begin
    logic lat3, lat4;
    vecs[0] = '{24, 32'h00A5C3F0, 1, 0, 24'hA5C3F0, 24};
    vecs[1] = '{23, 32'h007FFFFF, 0, 1, 24'hA5C3F0, 23};
    vecs[2] = '{26, 32'h03FFFFFF, 0, 1, 24'hA5C3F0, 25};
    vecs[3] = '{24, 32'h00123456, 1, 0, 24'h123456, 24};
    vecs[4] = '{24, 32'h00FEDCBA, 1, 0, 24'hFEDCBA, 24};
    vecs[5] = '{ 0, 32'h00000000, 0, 1, 24'hFEDCBA,  0};
    vecs[6] = '{24, 32'h00000000, 1, 0, 24'h000000, 24};
    vecs[7] = '{24, 32'h00FFFFFF, 1, 0, 24'hFFFFFF, 24};

    nd_cnt = 0; fe_cnt = 0; last_nd = '0;
    sck = 1'b0; mosi = 1'b0; CS = 1'b1; rst_n = 1'b0;
    #12;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_new_data", 32'(new_data), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(4);

    for (int v = 0; v < 8; v++) begin
      nd_cnt = 0; fe_cnt = 0;
      send_frame(vecs[v].value, vecs[v].nbits);
      tick(32);
      check($sformatf("v%0d_new_data_cycles", v), 32'(nd_cnt), 32'(vecs[v].exp_nd));
      check($sformatf("v%0d_frame_err_cycles", v), 32'(fe_cnt), 32'(vecs[v].exp_fe));
      check($sformatf("v%0d_data_out", v), 32'(data_out), 32'(vecs[v].exp_data));
      check($sformatf("v%0d_bit_cnt", v), 32'(dut.cnt), 32'(vecs[v].exp_cnt));
      check($sformatf("v%0d_busy_idle", v), 32'(busy), 32'h0);
      if (vecs[v].exp_nd != 0)
        check($sformatf("v%0d_pulse_value", v), 32'(last_nd), 32'(vecs[v].exp_data));
    end

    // new_data latency from CS high at the pin
    nd_cnt = 0;
    CS = 1'b0; tick(8);
    shift_bits(32'h00C0FFEE, 24);
    tick(8);
    CS = 1'b1;
    tick(3); lat3 = new_data;
    tick(1); lat4 = new_data;
    check("latency_edge3_low", 32'(lat3), 32'h0);
    check("latency_edge4_high", 32'(lat4), 32'h1);
    tick(20);
    check("latency_data", 32'(data_out), 32'h00C0FFEE);
    check("latency_one_pulse", 32'(nd_cnt), 32'h1);

    // sck fall coincident with CS rise is not sampled
    nd_cnt = 0; fe_cnt = 0;
    CS = 1'b0; tick(8);
    shift_bits(32'h000F0F0F, 24);
    sck = 1'b1; mosi = 1'b1; tick(8);
    sck = 1'b0; CS = 1'b1;
    tick(32);
    check("coinc_new_data", 32'(nd_cnt), 32'h1);
    check("coinc_frame_err", 32'(fe_cnt), 32'h0);
    check("coinc_data", 32'(data_out), 32'h000F0F0F);

    // Reset in the middle of a frame
    fe_cnt = 0;
    CS = 1'b0; tick(8);
    shift_bits(32'h000003FF, 10);
    check("midframe_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", 32'(data_out), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_new_data", 32'(new_data), 32'h0);
    check("arst_frame_err", 32'(frame_err), 32'h0);
    CS = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(20);
    check("arst_no_frame_err", 32'(fe_cnt), 32'h0);
    nd_cnt = 0;
    send_frame(32'h00000001, 24);
    tick(32);
    check("post_rst_data", 32'(data_out), 32'h000001);
    check("post_rst_new_data", 32'(nd_cnt), 32'h1);

    // sck stall inside a frame
    nd_cnt = 0; fe_cnt = 0;
    CS = 1'b0; tick(8);
    shift_bits(32'h00000015, 5);
    tick(300);
`ifdef MEMS_SPI_RX_TIMEOUT_EN
    check("timeout_frame_err", 32'(fe_cnt), 32'h1);
    check("timeout_busy", 32'(busy), 32'h0);
`else
    check("stall_no_frame_err", 32'(fe_cnt), 32'h0);
    check("stall_busy", 32'(busy), 32'h1);
`endif
    CS = 1'b1;
    tick(32);
    nd_cnt = 0; fe_cnt = 0;
    send_frame(32'h005A5A5A, 24);
    tick(32);
    check("after_stall_data", 32'(data_out), 32'h5A5A5A);
    check("after_stall_new_data", 32'(nd_cnt), 32'h1);
    check("after_stall_frame_err", 32'(fe_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
